// File: rtl/math_int_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package math_int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Special-case results; callers slice these to their operand width.
  localparam logic [63:0] DIV0_LO = '1;
  localparam logic [63:0] OVF_HI  = '0;

endpackage

// File: rtl/math_int_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and sign fix-up.
module math_int_negate #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/math_int_iter.sv
// Bit-serial multiply (shift-add) and restoring divide with signed/unsigned operands.
// Handshake: a transfer happens on an edge where valid and ready are both 1; o_valid holds until i_ready.
module math_int_iter
  import math_int_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_is_div,
  input  logic             i_op1_signed,
  input  logic             i_op2_signed,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [1:0]       o_state
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q, neg_res_q, neg_rem_q;
  logic [WIDTH:0]     hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH:0]     opb_q;
  logic               o_valid_q;
  logic [WIDTH-1:0]   o_lo_q, o_hi_q;

  logic               sign1, sign2, div0, ovf;
  logic [WIDTH:0]     mag1, mag2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     mul_hi_d;
  logic [WIDTH-1:0]   mul_lo_d;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH:0]     div_rem_d;
  logic [WIDTH-1:0]   div_quo_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign sign1 = i_op1_signed & i_op1[WIDTH-1];
  assign sign2 = i_op2_signed & i_op2[WIDTH-1];
  assign div0  = i_is_div & (i_op2 == '0);
  assign ovf   = i_is_div & i_op1_signed & i_op2_signed & (i_op1 == MOST_NEG) & (&i_op2);

  // Magnitudes are one bit wider so the most-negative operand stays representable.
  math_int_negate #(.W(WIDTH+1)) u_abs1 (.i_val({sign1, i_op1}), .i_neg(sign1), .o_val(mag1));
  math_int_negate #(.W(WIDTH+1)) u_abs2 (.i_val({sign2, i_op2}), .i_neg(sign2), .o_val(mag2));

  math_int_negate #(.W(2*WIDTH)) u_fix_p (.i_val({hi_q[WIDTH-1:0], lo_q}), .i_neg(neg_res_q), .o_val(prod_fix));
  math_int_negate #(.W(WIDTH))   u_fix_q (.i_val(lo_q), .i_neg(neg_res_q), .o_val(quo_fix));
  math_int_negate #(.W(WIDTH))   u_fix_r (.i_val(hi_q[WIDTH-1:0]), .i_neg(neg_rem_q), .o_val(rem_fix));

  always_comb begin
    mul_sum   = hi_q + (lo_q[0] ? opb_q : '0);
    mul_hi_d  = {1'b0, mul_sum[WIDTH:1]};
    mul_lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {1'b0, opb_q};
    div_rem_d = div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
    div_quo_d = {lo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      o_valid_q <= 1'b0;
      o_lo_q    <= '0;
      o_hi_q    <= '0;
    end else if (i_flush) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_lo_q    <= '0;
      o_hi_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            if (div0) begin
              o_lo_q    <= DIV0_LO[WIDTH-1:0];
              o_hi_q    <= i_op1;
              o_valid_q <= 1'b1;
              state_q   <= DONE;
            end else if (ovf) begin
              o_lo_q    <= i_op1;
              o_hi_q    <= OVF_HI[WIDTH-1:0];
              o_valid_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              is_div_q  <= i_is_div;
              neg_res_q <= sign1 ^ sign2;
              neg_rem_q <= sign1;
              cnt_q     <= CNT_W'(WIDTH);
              hi_q      <= '0;
              lo_q      <= i_is_div ? mag1[WIDTH-1:0] : mag2[WIDTH-1:0];
              opb_q     <= i_is_div ? mag2 : mag1;
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            hi_q  <= is_div_q ? div_rem_d : mul_hi_d;
            lo_q  <= is_div_q ? div_quo_d : mul_lo_d;
          end else begin
            state_q <= FIX;
          end
        end
        FIX: begin
          o_lo_q    <= is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
          o_hi_q    <= is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          o_valid_q <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid_q <= 1'b0;
            o_lo_q    <= '0;
            o_hi_q    <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = o_valid_q;
  assign o_lo    = o_lo_q;
  assign o_hi    = o_hi_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_math_int_iter.sv
// Self-checking bench for math_int_iter at WIDTH=32: fixed vectors, random ops vs a plain-arithmetic model, corner sequences.
module tb_math_int_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0, is_div = 1'b0, s1 = 1'b0, s2 = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [W-1:0] op1 = '0, op2 = '0;
  logic         ready, valid;
  logic [W-1:0] lo, hi;
  logic [1:0]   state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] exp_q[$];

  math_int_iter #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_valid(in_valid), .o_ready(ready),
    .i_is_div(is_div), .i_op1_signed(s1), .i_op2_signed(s2), .i_op1(op1), .i_op2(op2),
    .i_flush(flush), .o_valid(valid), .i_ready(out_ready), .o_lo(lo), .o_hi(hi), .o_state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         d, a_s, b_s;
    logic [W-1:0] a, b, e_lo, e_hi;
    int           e_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: {hi, lo} from two's-complement arithmetic on 64-bit extended operands.
  function automatic logic [2*W-1:0] model(input logic d, input logic a_s, input logic b_s,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] ea, eb;
    longint sa, sb, q, r;
    ea = a_s ? {{32{a[W-1]}}, a} : {32'b0, a};
    eb = b_s ? {{32{b[W-1]}}, b} : {32'b0, b};
    if (!d) return ea * eb;
    if (b == '0) return {a, 32'hFFFF_FFFF};
    if (a_s && b_s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
    sa = $signed(ea);
    sb = $signed(eb);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Edges after the accept edge until o_valid is seen: 34 normally, 0 for special cases.
  function automatic int model_lat(input logic d, input logic a_s, input logic b_s,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
    if (d && (b == '0 || (a_s && b_s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
    return W + 2;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drive one request at a negedge; returns after the accept edge (#1).
  task automatic issue(input logic d, input logic a_s, input logic b_s,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("wait_ready_timeout", 1, 0);
    is_div = d; s1 = a_s; s2 = b_s; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait for o_valid after the accept edge; lat = -1 on timeout.
  task automatic wait_result(output int lat, output logic [W-1:0] r_lo, output logic [W-1:0] r_hi);
    lat = 0;
    while (!valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!valid) lat = -1;
    r_lo = lo;
    r_hi = hi;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic d, input logic a_s, input logic b_s,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int e_lat);
    int lat;
    logic [W-1:0] r_lo, r_hi;
    logic [2*W-1:0] e;
    issue(d, a_s, b_s, a, b);
    wait_result(lat, r_lo, r_hi);
    e = exp_q.pop_front();
    check({name, "_lat"}, 64'(lat), 64'(e_lat));
    check({name, "_lo"}, 64'(r_lo), 64'(e[W-1:0]));
    check({name, "_hi"}, 64'(r_hi), 64'(e[2*W-1:W]));
    if (lat >= 0) consume();
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    check(name, 64'(seen), 0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 34};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 34};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005, 0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         34};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 34};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 34};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 34};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 34};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0};

    do_reset();
    @(negedge clk);
    check("reset_ready", 64'(ready), 1);
    check("reset_valid", 64'(valid), 0);
    check("reset_lo", 64'(lo), 0);
    check("reset_hi", 64'(hi), 0);

    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].e_hi, vecs[i].e_lo});
      run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].a_s, vecs[i].b_s,
             vecs[i].a, vecs[i].b, vecs[i].e_lat);
    end

    for (int k = 0; k < 40; k++) begin
      logic d, a_s, b_s;
      logic [W-1:0] a, b;
      d   = 1'($urandom_range(0, 1));
      a_s = 1'($urandom_range(0, 1));
      b_s = 1'($urandom_range(0, 1));
      a   = $urandom();
      b   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : $urandom();
      if ($urandom_range(0, 7) == 0) b = '1;
      exp_q.push_back(model(d, a_s, b_s, a, b));
      run_op($sformatf("rand%0d", k), d, a_s, b_s, a, b, model_lat(d, a_s, b_s, a, b));
    end

    // Backpressure: result must hold for 5 cycles, and a concurrent i_valid is ignored.
    begin
      int lat;
      logic [W-1:0] r_lo, r_hi;
      logic stable;
      issue(1'b0, 1'b0, 1'b0, 32'd6, 32'd7);
      wait_result(lat, r_lo, r_hi);
      check("bp_lat", 64'(lat), 34);
      check("bp_lo", 64'(r_lo), 42);
      stable = 1'b1;
      @(negedge clk);
      op1 = 32'd9; op2 = 32'd9; is_div = 1'b0; in_valid = 1'b1;
      repeat (5) begin
        if (!valid || lo !== 32'd42 || hi !== 32'd0 || ready) stable = 1'b0;
        @(negedge clk);
      end
      check("bp_stable", 64'(stable), 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b0;
      check("bp_idle_ready", 64'(ready), 1);
      check("bp_valid_low", 64'(valid), 0);
      watch_no_valid("bp_no_accept", 40);
    end

    // Flush at CALC cycle 10, then a clean 6 / 3.
    issue(1'b1, 1'b0, 1'b0, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_ready", 64'(ready), 1);
    check("flush_valid", 64'(valid), 0);
    watch_no_valid("flush_no_valid", 40);
    exp_q.push_back({32'd0, 32'd2});
    run_op("after_flush", 1'b1, 1'b0, 1'b0, 32'd6, 32'd3, 34);

    // Flush wins over i_valid in IDLE.
    @(negedge clk);
    is_div = 1'b0; op1 = 32'd3; op2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", 64'(ready), 1);
    watch_no_valid("flush_idle_no_valid", 40);

    // Reset for one cycle mid-CALC.
    issue(1'b0, 1'b1, 1'b0, 32'hFFFF_FF00, 32'd77);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ready", 64'(ready), 1);
    check("rst_mid_valid", 64'(valid), 0);
    check("rst_mid_lo", 64'(lo), 0);
    check("rst_mid_hi", 64'(hi), 0);
    @(negedge clk);
    reset_n = 1'b1;
    watch_no_valid("rst_mid_no_valid", 40);
    exp_q.push_back(model(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5));
    run_op("after_reset", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
